// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet TX scheduler.
// Requester indices, FSM states and the round-robin pick.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        GAP
    } state_t;

    localparam int N_REQ   = 2;
    localparam int REQ_CMD = 0;
    localparam int REQ_ARP = 1;

    // prio = 0 favours the command path, 1 favours ARP replies
    function automatic logic [N_REQ-1:0] rr_pick(
        input logic [N_REQ-1:0] pend,
        input logic             prio
    );
        logic [N_REQ-1:0] w;
        w = '0;
        if (pend[REQ_CMD] && pend[REQ_ARP]) begin
            if (prio) w[REQ_ARP] = 1'b1;
            else      w[REQ_CMD] = 1'b1;
        end else begin
            w = pend;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter with a synchronous clear.
// Clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W  = 16,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] inc,
    input  logic          clr,
    output logic [W-1:0]  cnt
);

    logic [W:0] sum;

    assign sum = {1'b0, cnt} + {{(W + 1 - IW){1'b0}}, inc};

    // Add the step, pinning at all-ones on overflow
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc != '0) begin
            cnt <= sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Shares the frame sender between the NIOS command path and ARP replies.
// Round-robin grant, start pulse, tx_en tracking, inter-frame gap, IRQ.
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_tx_en,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_send,
    output logic             o_busy,
    output logic [N_REQ-1:0] o_pending,
    output logic             o_irq_tx,
    output logic             o_timeout,
    input  logic             i_clr_stat,
    output logic [CNT_W-1:0] o_sent_cnt,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam int TMAX = (START_TIMEOUT > IFG_CYCLES) ?
                          START_TIMEOUT : IFG_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] TMO_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] take;
    logic [N_REQ-1:0] drop;
    logic [1:0]       drop_inc;
    logic             send_q, send_d;
    logic             irq_q, irq_d;
    logic             prio_q, prio_d;
    logic             tmo_q, tmo_set;
    logic             sent_inc;

    // Register the FSM, grant, pulses, pending set and sticky timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            pend_q  <= '0;
            send_q  <= 1'b0;
            irq_q   <= 1'b0;
            prio_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            pend_q  <= pend_d;
            send_q  <= send_d;
            irq_q   <= irq_d;
            prio_q  <= prio_d;
            tmo_q   <= i_clr_stat ? 1'b0 : (tmo_q | tmo_set);
        end
    end

    // Next state: arbitrate in IDLE, then start, track and gap
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        prio_d   = prio_q;
        send_d   = 1'b0;
        irq_d    = 1'b0;
        tmo_set  = 1'b0;
        sent_inc = 1'b0;
        take     = '0;
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    take    = rr_pick(pend_q, prio_q);
                    if (&pend_q) prio_d = ~prio_q;
                    grant_d = take;
                    send_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (i_tx_en) begin
                    state_d = BUSY;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_set = 1'b1;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BUSY: begin
                if (!i_tx_en) begin
                    irq_d    = 1'b1;
                    sent_inc = 1'b1;
                    grant_d  = '0;
                    cnt_d    = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Latch requests; a repeat on a still-pending bit is a drop
    always_comb begin
        pend_d   = (pend_q & ~take) | i_req;
        drop     = i_req & pend_q & ~take;
        drop_inc = {1'b0, drop[REQ_CMD]} + {1'b0, drop[REQ_ARP]};
    end

    sat_counter #(
        .W  (CNT_W),
        .IW (1)
    ) u_sent_cnt (
        .clk (clk),
        .rst (rst),
        .inc (sent_inc),
        .clr (i_clr_stat),
        .cnt (o_sent_cnt)
    );

    sat_counter #(
        .W  (CNT_W),
        .IW (2)
    ) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .clr (i_clr_stat),
        .cnt (o_drop_cnt)
    );

    assign o_grant   = grant_q;
    assign o_send    = send_q;
    assign o_busy    = (state_q != IDLE);
    assign o_pending = pend_q;
    assign o_irq_tx  = irq_q;
    assign o_timeout = tmo_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched with a behavioural frame sender.
// Stimulus pushes expected grants/counts; a monitor pops on DUT events.
module tb_eth_tx_sched;

    localparam int IFG   = 12;
    localparam int TMO   = 64;
    localparam int CW    = 4;
    localparam int FRAME = 60;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_req;
    logic          i_tx_en;
    logic          i_clr_stat;
    logic          clr_stim;
    logic          clr_fall;
    logic [1:0]    o_grant;
    logic          o_send;
    logic          o_busy;
    logic [1:0]    o_pending;
    logic          o_irq_tx;
    logic          o_timeout;
    logic [CW-1:0] o_sent_cnt;
    logic [CW-1:0] o_drop_cnt;

    bit sender_en;
    bit abort_tx;
    bit clr_at_fall;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]    exp_grant[$];
    logic [CW-1:0] exp_sent[$];
    int            exp_tmo[$];

    int   tick = 0;
    int   send_tick = 0;
    int   fall_tick = 0;
    bit   fall_valid = 0;
    bit   pend_at_irq = 0;
    logic txp = 1'b0;
    logic tmo_prev = 1'b0;

    assign i_clr_stat = clr_stim | clr_fall;

    eth_tx_sched #(
        .IFG_CYCLES    (IFG),
        .START_TIMEOUT (TMO),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_tx_en    (i_tx_en),
        .o_grant    (o_grant),
        .o_send     (o_send),
        .o_busy     (o_busy),
        .o_pending  (o_pending),
        .o_irq_tx   (o_irq_tx),
        .o_timeout  (o_timeout),
        .i_clr_stat (i_clr_stat),
        .o_sent_cnt (o_sent_cnt),
        .o_drop_cnt (o_drop_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, expected no event", name, act);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [1:0] r);
        i_req = r;
        @(negedge clk);
        i_req = 2'b00;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!o_busy && o_pending == 2'b00) break;
            @(negedge clk);
        end
        check("idle_reached", (i < budget), 1);
    endtask

    task automatic wait_tx(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (i_tx_en) break;
            @(negedge clk);
        end
        check("tx_en_rise", (i < budget), 1);
    endtask

    task automatic wait_tmo(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (o_timeout) break;
            @(negedge clk);
        end
        check("timeout_seen", (i < budget), 1);
    endtask

    // Frame sender: tx_en rises 3 clks after o_send, lasts FRAME clks
    initial begin
        i_tx_en  = 1'b0;
        clr_fall = 1'b0;
        forever begin
            @(negedge clk);
            if (o_send && sender_en && !rst) begin
                repeat (3) @(negedge clk);
                i_tx_en = 1'b1;
                for (int i = 0; i < FRAME; i++) begin
                    @(negedge clk);
                    if (abort_tx) break;
                end
                i_tx_en  = 1'b0;
                clr_fall = clr_at_fall && !abort_tx;
                @(negedge clk);
                clr_fall = 1'b0;
            end
        end
    end

    // Monitor: sample just after each rising edge, pop on DUT events
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick++;
            if (rst) begin
                fall_valid = 0;
            end else begin
                if (o_send) begin
                    if (exp_grant.size() == 0)
                        fail_evt("send_unexpected", o_grant);
                    else
                        check("grant_at_send", o_grant,
                              exp_grant.pop_front());
                    if (fall_valid) begin
                        if (pend_at_irq)
                            check("ifg_gap", tick - fall_tick, IFG + 1);
                        else
                            check("ifg_min",
                                  (tick - fall_tick >= IFG + 1), 1);
                    end
                    fall_valid = 0;
                    send_tick  = tick;
                end
                if (o_irq_tx) begin
                    check("irq_after_fall", {txp, i_tx_en}, 2'b10);
                    if (exp_sent.size() == 0)
                        fail_evt("irq_unexpected", o_sent_cnt);
                    else
                        check("sent_at_irq", o_sent_cnt,
                              exp_sent.pop_front());
                    fall_valid  = 1;
                    fall_tick   = tick;
                    pend_at_irq = |o_pending;
                end
                if (o_timeout && !tmo_prev) begin
                    if (exp_tmo.size() == 0) begin
                        fail_evt("timeout_unexpected", o_timeout);
                    end else begin
                        check("timeout_delay", tick - send_tick,
                              exp_tmo.pop_front());
                        check("timeout_grant", o_grant, 0);
                        check("timeout_no_irq", o_irq_tx, 0);
                    end
                end
            end
            txp      = i_tx_en;
            tmo_prev = o_timeout;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        i_req       = 2'b00;
        clr_stim    = 1'b0;
        sender_en   = 1;
        abort_tx    = 0;
        clr_at_fall = 0;
        step(3);
        rst = 1'b0;
        check("rst_grant", o_grant, 0);
        check("rst_send", o_send, 0);
        check("rst_busy", o_busy, 0);
        check("rst_pending", o_pending, 0);
        check("rst_irq", o_irq_tx, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_sent", o_sent_cnt, 0);
        check("rst_drop", o_drop_cnt, 0);

        // single command request
        exp_grant.push_back(2'b01);
        exp_sent.push_back(4'd1);
        pulse_req(2'b01);
        check("single_pend", o_pending, 2'b01);
        check("single_nogrant", o_grant, 2'b00);
        step(1);
        check("single_grant", o_grant, 2'b01);
        check("single_send", o_send, 1);
        check("single_busy", o_busy, 1);
        check("single_pend_clr", o_pending, 2'b00);
        step(1);
        check("single_send_1clk", o_send, 0);
        check("single_grant_hold", o_grant, 2'b01);
        wait_idle(300);
        check("single_sent", o_sent_cnt, 1);

        // simultaneous requests, twice: pointer advances
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        exp_sent.push_back(4'd2);
        exp_sent.push_back(4'd3);
        pulse_req(2'b11);
        wait_idle(400);
        exp_grant.push_back(2'b10);
        exp_grant.push_back(2'b01);
        exp_sent.push_back(4'd4);
        exp_sent.push_back(4'd5);
        pulse_req(2'b11);
        wait_idle(400);
        check("rr_sent", o_sent_cnt, 5);

        // start timeout on an ARP request
        sender_en = 0;
        exp_grant.push_back(2'b10);
        exp_tmo.push_back(TMO);
        pulse_req(2'b10);
        wait_tmo(200);
        step(IFG - 1);
        check("tmo_gap_busy", o_busy, 1);
        step(1);
        check("tmo_gap_idle", o_busy, 0);
        check("tmo_sent_kept", o_sent_cnt, 5);
        check("tmo_sticky", o_timeout, 1);
        clr_stim = 1'b1;
        step(1);
        clr_stim = 1'b0;
        check("tmo_cleared", o_timeout, 0);
        check("clr_sent", o_sent_cnt, 0);
        sender_en = 1;

        // drops while busy
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b01);
        exp_sent.push_back(4'd1);
        exp_sent.push_back(4'd2);
        pulse_req(2'b01);
        wait_tx(50);
        step(2);
        for (int k = 0; k < 3; k++) begin
            pulse_req(2'b01);
            step(1);
        end
        check("drop_pend", o_pending, 2'b01);
        check("drop_cnt", o_drop_cnt, 2);
        wait_idle(400);
        check("drop_sent", o_sent_cnt, 2);

        // clear in the same clock as the completion increment
        clr_at_fall = 1;
        exp_grant.push_back(2'b01);
        exp_sent.push_back(4'd0);
        pulse_req(2'b01);
        wait_idle(300);
        clr_at_fall = 0;
        check("clr_wins_sent", o_sent_cnt, 0);
        check("clr_drop", o_drop_cnt, 0);

        // drop counter saturation with double drops
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        exp_sent.push_back(4'd1);
        exp_sent.push_back(4'd2);
        exp_sent.push_back(4'd3);
        pulse_req(2'b01);
        wait_tx(50);
        step(1);
        pulse_req(2'b11);
        step(1);
        check("sat_first_nodrop", o_drop_cnt, 0);
        for (int k = 0; k < 7; k++) begin
            pulse_req(2'b11);
            step(1);
        end
        check("sat_drop14", o_drop_cnt, 14);
        pulse_req(2'b11);
        step(1);
        check("sat_drop_max", o_drop_cnt, 15);
        pulse_req(2'b11);
        step(1);
        check("sat_drop_hold", o_drop_cnt, 15);
        wait_idle(600);

        // reset mid-frame
        exp_grant.push_back(2'b01);
        pulse_req(2'b01);
        wait_tx(50);
        step(5);
        pulse_req(2'b10);
        abort_tx = 1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_grant", o_grant, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_pending", o_pending, 0);
        check("mrst_sent", o_sent_cnt, 0);
        check("mrst_drop", o_drop_cnt, 0);
        check("mrst_irq", o_irq_tx, 0);
        step(3);
        abort_tx = 0;
        step(2);
        exp_grant.push_back(2'b01);
        exp_sent.push_back(4'd1);
        pulse_req(2'b01);
        wait_idle(300);
        check("post_rst_sent", o_sent_cnt, 1);

        step(5);
        check("grant_queue_empty", exp_grant.size(), 0);
        check("sent_queue_empty", exp_sent.size(), 0);
        check("tmo_queue_empty", exp_tmo.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
Scheduler that shares the single frame transmitter between two requesters: requester 0 is the NIOS-II command path and requester 1 is the automatic ARP-reply path from the receive side. Latches requests and arbitrates round-robin. Issues a one-cycle start pulse to the transmitter, tracks the frame via tx_en, enforces the inter-frame gap and raises a TX-done interrupt. Sits in the TX clock domain between the command/receive logic and the frame sender.

Parameters:
IFG_CYCLES, 12, idle clocks enforced after tx_en falls before the next start (byte clocks).
START_TIMEOUT, 64, clocks to wait for tx_en to rise after a start pulse before aborting.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  TX byte clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
i_req  in  2  request pulses; bit0 = NIOS command, bit1 = ARP auto-reply.
i_tx_en  in  1  tx_en monitored from the frame sender.
o_grant  out  2  one-hot owner of the sender; steers the external parameter mux; 0 when idle.
o_send  out  1  one-cycle start pulse to the sender.
o_busy  out  1  high in any state other than IDLE.
o_pending  out  2  latched, not-yet-served requests.
o_irq_tx  out  1  one-cycle pulse on successful frame completion.
o_timeout  out  1  sticky; set on start timeout; cleared by i_clr_stat.
i_clr_stat  in  1  synchronous clear of the counters and o_timeout.
o_sent_cnt  out  CNT_W  frames completed; saturating.
o_drop_cnt  out  CNT_W  requests lost because the same bit was already pending; saturating.

Behaviour:
- Reset: all outputs 0. State IDLE. Round-robin pointer = requester 0 has priority.
- Pending: on i_req[k], pending[k] is set. If pending[k] is already 1 (and is not being cleared this cycle), drop_cnt increments, saturating at all-ones. A request on a bit cleared in the same cycle re-sets it and is not counted as a drop.
- IDLE: if pending != 0, pick the winner. When both bits are set, the winner is the requester with priority, and priority then passes to the other requester. Then:
  - set o_grant to the winner one-hot;
  - clear pending[winner];
  - go to START.
  - Grant latency: 1 clk after the pending bit is visible.
- START: o_send = 1 on the first cycle only; o_grant is held. Wait-counter starts at 0.
  - i_tx_en = 1 -> BUSY.
  - Counter reaching START_TIMEOUT-1 with no tx_en -> set o_timeout, clear o_grant, go to GAP. No irq, no sent_cnt.
- BUSY: hold o_grant. When i_tx_en = 0 -> pulse o_irq_tx, increment sent_cnt (saturating), clear o_grant, go to GAP.
- GAP: count IFG_CYCLES clocks with o_grant = 0, then go to IDLE. The next o_send comes no earlier than IFG_CYCLES+2 clocks after tx_en falls.
- Requests arriving in any state only update pending; they never pre-empt the frame in flight.
- i_clr_stat together with an increment in the same cycle: clear wins, result 0. Same rule for o_timeout set and clear.
- Reset mid-frame returns to IDLE immediately with grant removed. The sender is reset by the same system reset.
- i_tx_en high while IDLE or GAP (sender glitch) is ignored.

Decomposition:
- Package eth_pkg holds:
  - state typedef enum {IDLE, START, BUSY, GAP};
  - constants REQ_CMD = 0 and REQ_ARP = 1;
  - localparam N_REQ = 2.
- One sub-module, sat_counter (CNT_W wide, inc/clr inputs, clr priority), instantiated twice for sent_cnt and drop_cnt.

Test Plan:
- Single request: i_req=01 pulse; model drives tx_en high 3 clks after o_send for 60 clks. Expect:
  - o_grant=01 one clk after the pending bit is set;
  - o_send high 1 clk;
  - o_irq_tx 1 clk after tx_en falls;
  - sent_cnt=1;
  - next start blocked for 12 clks.
- Simultaneous requests: i_req=11 in one clk. Expect grant=01 first, then grant=10 after the 60-clk frame plus gap. Repeat i_req=11: order is 10 then 01 (round-robin pointer advanced).
- Timeout: i_req=10 with tx_en held 0. Expect:
  - o_timeout=1 after 64 clks in START;
  - grant drops;
  - no irq, sent_cnt unchanged;
  - returns to IDLE after 12 gap clks.
  - Then i_clr_stat -> o_timeout=0.
- Drops: while BUSY, pulse i_req=01 three times. Expect pending=01, drop_cnt=2, and exactly one further frame.
- Clear vs increment: assert i_clr_stat in the same clk as the irq. Expect sent_cnt=0 afterwards. Preload drop_cnt near all-ones and overflow it: holds at all-ones.
- Reset mid-BUSY: assert rst for 1 clk. Expect the next clk to show o_grant=0, o_busy=0, pending=0, counters=0, and the state machine in IDLE.
